// File: rtl/stub_page_reader_pkg.sv
// ============================================================================
// Module      : stub_page_reader_pkg
// Description : Shared constants, FSM encoding and helpers for the stub page
//               reader (stub width, page-address split, default TMUX).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package stub_page_reader_pkg;

  // Processing-window length: start-to-done delay in clocks.
  localparam int c_TMUX   = 6;

  // Stub word width and page-address split {bx, idx}.
  localparam int c_STUB_W = 36;
  localparam int c_BX_W   = 3;
  localparam int c_IDX_W  = 6;
  localparam int c_ADDR_W = c_BX_W + c_IDX_W;

  // Two-state reader FSM, explicitly encoded.
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_READ = 1'b1;

  // Read address after reset: BX field all ones, index zero.
  localparam logic [c_ADDR_W-1:0] c_ADDR_RESET = {{c_BX_W{1'b1}}, {c_IDX_W{1'b0}}};

  // Limit the page stub count to the largest count the reader will drain.
  function automatic logic [c_IDX_W-1:0] clamp_count(
    input logic [c_IDX_W-1:0] n,
    input logic [c_IDX_W-1:0] max_n
  );
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stub_page_reader_pipe_delay.sv
// ============================================================================
// Module      : pipe_delay
// Description : Fixed-length register delay line with synchronous clear.
//               dout equals din delayed by exactly STAGES clocks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_delay #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the delay line one stage per clock; clear flushes every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dout = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/stub_page_reader.sv
// ============================================================================
// Module      : stub_page_reader
// Description : Drains one BX page of the disk stub memory per processing
//               window and streams the stubs out with valid and index aligned
//               to the registered read data.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stub_page_reader
  import stub_page_reader_pkg::*;
#(
  parameter int RD_LATENCY = 3,
  parameter int TMUX       = c_TMUX,
  parameter int MAX_STUBS  = 63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_proc,
  input  logic [1:0]          start,
  output logic [1:0]          done,
  input  logic [c_IDX_W-1:0]  number_in,
  output logic [c_ADDR_W-1:0] read_add,
  input  logic [c_STUB_W-1:0] data_in,
  output logic [c_STUB_W-1:0] data_out,
  output logic                valid_out,
  output logic [c_IDX_W-1:0]  index_out,
  output logic                truncated
);

  localparam logic [c_IDX_W-1:0] c_MAX_CNT = c_IDX_W'(MAX_STUBS);

  // start[1] acts as a pipelined reset for everything except the done line.
  logic w_clear;
  assign w_clear = reset | start[1];

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [c_BX_W-1:0]   r_bx_rd,    w_bx_nxt;
  logic [c_IDX_W-1:0]  r_idx,      w_idx_nxt;
  logic [c_IDX_W-1:0]  r_cnt,      w_cnt_nxt;
  logic [c_ADDR_W-1:0] r_read_add, w_read_add_nxt;
  logic                r_issue,    w_issue_nxt;
  logic                w_trunc_nxt;
  logic                w_last_issue;

  logic                w_issue_dly;
  logic [c_IDX_W-1:0]  w_idx_dly;

  logic [c_STUB_W-1:0] r_data_out;
  logic                r_valid_out;
  logic [c_IDX_W-1:0]  r_index_out;
  logic                r_truncated;

  // The issue in flight is the final one of the page.
  assign w_last_issue = (r_idx == (r_cnt - c_IDX_W'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= c_ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: a page start always restarts the FSM; otherwise leave READ after the last issue.
  always_comb begin
    w_state_nxt = r_state;
    if (start[0]) begin
      w_state_nxt = (number_in != '0) ? c_ST_READ : c_ST_IDLE;
    end else if ((r_state == c_ST_READ) && en_proc && w_last_issue) begin
      w_state_nxt = c_ST_IDLE;
    end
  end

  // Datapath next values: page setup on start, one address issue per enabled READ cycle.
  always_comb begin
    w_bx_nxt       = r_bx_rd;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_read_add_nxt = r_read_add;
    w_issue_nxt    = 1'b0;
    w_trunc_nxt    = 1'b0;
    if (start[0]) begin
      w_bx_nxt    = r_bx_rd + c_BX_W'(1);
      w_cnt_nxt   = clamp_count(number_in, c_MAX_CNT);
      w_idx_nxt   = '0;
      w_trunc_nxt = (r_state == c_ST_READ);
    end else if ((r_state == c_ST_READ) && en_proc) begin
      w_read_add_nxt = {r_bx_rd, r_idx};
      w_issue_nxt    = 1'b1;
      w_idx_nxt      = r_idx + c_IDX_W'(1);
    end
  end

  // Address-side registers.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_bx_rd     <= '1;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_read_add  <= c_ADDR_RESET;
      r_issue     <= 1'b0;
      r_truncated <= 1'b0;
    end else begin
      r_bx_rd     <= w_bx_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_read_add  <= w_read_add_nxt;
      r_issue     <= w_issue_nxt;
      r_truncated <= w_trunc_nxt;
    end
  end

  // Carry the issue flag and index alongside the memory read latency.
  pipe_delay #(
    .WIDTH  (1 + c_IDX_W),
    .STAGES (RD_LATENCY)
  ) u_issue_dly (
    .clk   (clk),
    .reset (w_clear),
    .din   ({r_issue, r_read_add[c_IDX_W-1:0]}),
    .dout  ({w_issue_dly, w_idx_dly})
  );

  // Output register: capture the stub when its delayed issue flag arrives.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_index_out <= '0;
    end else begin
      r_valid_out <= w_issue_dly;
      r_index_out <= w_idx_dly;
      if (w_issue_dly) r_data_out <= data_in;
    end
  end

  // done tracks start by TMUX clocks; only a hard reset flushes it so start[1] still propagates.
  pipe_delay #(
    .WIDTH  (2),
    .STAGES (TMUX)
  ) u_done_dly (
    .clk   (clk),
    .reset (reset),
    .din   (start),
    .dout  (done)
  );

  assign read_add  = r_read_add;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign index_out = r_index_out;
  assign truncated = r_truncated;

endmodule

`default_nettype wire

// File: tb/tb_stub_page_reader.sv
// ============================================================================
// Module      : tb_stub_page_reader
// Description : Self-checking bench for stub_page_reader: a cycle-indexed
//               behavioural model of pages/stubs plus directed literal checks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stub_page_reader;

  localparam int RD_LATENCY = 3;
  localparam int TMUX       = 6;
  localparam int MAX_STUBS  = 63;
  localparam int NC         = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_proc;
  logic [1:0]  start;
  logic [1:0]  done;
  logic [5:0]  number_in;
  logic [8:0]  read_add;
  logic [35:0] data_in;
  logic [35:0] data_out;
  logic        valid_out;
  logic [5:0]  index_out;
  logic        truncated;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stub_page_reader #(
    .RD_LATENCY (RD_LATENCY),
    .TMUX       (TMUX),
    .MAX_STUBS  (MAX_STUBS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en_proc   (en_proc),
    .start     (start),
    .done      (done),
    .number_in (number_in),
    .read_add  (read_add),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .index_out (index_out),
    .truncated (truncated)
  );

  // Upstream memory: returns data equal to the address, RD_LATENCY clocks later.
  logic [8:0] mem_pipe [RD_LATENCY];
  always_ff @(posedge clk) begin
    mem_pipe[0] <= read_add;
    for (int i = 1; i < RD_LATENCY; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign data_in = {27'd0, mem_pipe[RD_LATENCY-1]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (per clock edge k) ----------------
  bit          ev [NC];
  logic [35:0] ed [NC];
  logic [5:0]  ei [NC];
  bit          et [NC];
  logic [1:0]  st_hist [NC];
  int          last_rst = -1;
  bit          m_ok = 0;
  logic [2:0]  m_bx;
  bit          m_active;
  int          m_n, m_next;
  logic [8:0]  m_ra;
  int          k = 0;

  initial begin
    forever begin
      @(negedge clk);
      // Inputs still hold what the last posedge sampled.
      st_hist[k] = start;
      if (reset) begin
        m_ok     = 1;
        last_rst = k;
      end
      if (reset || start[1]) begin
        m_bx     = 3'd7;
        m_active = 0;
        m_ra     = 9'h1C0;
        for (int j = k; j < k + RD_LATENCY + 3 && j < NC; j++) ev[j] = 0;
        et[k] = 0;
      end else begin
        et[k] = start[0] && m_active;
        if (start[0]) begin
          m_bx     = m_bx + 3'd1;
          m_n      = (int'(number_in) > MAX_STUBS) ? MAX_STUBS : int'(number_in);
          m_active = (m_n != 0);
          m_next   = 0;
        end else if (m_active && en_proc) begin
          m_ra = {m_bx, 6'(m_next)};
          if (k + RD_LATENCY + 1 < NC) begin
            ev[k + RD_LATENCY + 1] = 1;
            ed[k + RD_LATENCY + 1] = {27'd0, m_ra};
            ei[k + RD_LATENCY + 1] = 6'(m_next);
          end
          m_next++;
          if (m_next == m_n) m_active = 0;
        end
      end
      if (m_ok) begin
        chk("read_add", 64'(read_add), 64'(m_ra));
        chk("valid_out", 64'(valid_out), 64'(ev[k]));
        if (ev[k]) begin
          chk("data_out", 64'(data_out), 64'(ed[k]));
          chk("index_out", 64'(index_out), 64'(ei[k]));
        end
        chk("truncated", 64'(truncated), 64'(et[k]));
        if (k - TMUX + 1 <= last_rst) chk("done", 64'(done), 64'd0);
        else                          chk("done", 64'(done), 64'(st_hist[k-TMUX+1]));
      end
      k++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [1:0] st, input logic [5:0] n, input logic e, input logic r);
    reset     = r;
    start     = st;
    number_in = n;
    en_proc   = e;
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    repeat (2) drive(2'b00, 6'd0, 1'b1, 1'b1);
    repeat (2) drive(2'b00, 6'd0, 1'b1, 1'b0);
  endtask

  int vcnt;

  initial begin
    reset = 1'b1; start = 2'b00; number_in = '0; en_proc = 1'b0;
    do_reset();
    chk("reset read_add", 64'(read_add), 64'h1C0);
    chk("reset valid_out", 64'(valid_out), 64'd0);

    // Three-stub page: addresses 0..2, outputs 5 clocks after start.
    drive(2'b01, 6'd3, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(2'b00, 6'd0, 1'b1, 1'b0);
      if (i <= 3) chk("t1 read_add", 64'(read_add), 64'(i - 1));
      chk("t1 valid", 64'(valid_out), 64'(i >= 5 && i <= 7));
      if (i >= 5 && i <= 7) begin
        chk("t1 data", 64'(data_out), 64'(i - 5));
        chk("t1 index", 64'(index_out), 64'(i - 5));
      end
    end

    // Eight two-stub pages cycle through every BX then wrap.
    do_reset();
    for (int p = 0; p < 9; p++) begin
      drive(2'b01, 6'd2, 1'b1, 1'b0);
      drive(2'b00, 6'd0, 1'b1, 1'b0);
      chk("rr bx", 64'(read_add[8:6]), 64'(p % 8));
      drive(2'b00, 6'd0, 1'b1, 1'b0);
      drive(2'b00, 6'd0, 1'b1, 1'b0);
    end
    repeat (8) drive(2'b00, 6'd0, 1'b1, 1'b0);

    // Stall for two cycles after the second issue.
    do_reset();
    drive(2'b01, 6'd5, 1'b1, 1'b0);
    drive(2'b00, 6'd0, 1'b1, 1'b0);
    drive(2'b00, 6'd0, 1'b1, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 6'd0, 1'b0, 1'b0);
      chk("stall hold", 64'(read_add), 64'h001);
    end
    for (int i = 0; i < 14; i++) begin
      drive(2'b00, 6'd0, 1'b1, 1'b0);
      if (valid_out) vcnt++;
    end
    chk("stall valid count", 64'(vcnt), 64'd5);

    // Abandon a 40-stub page after 10 issues.
    do_reset();
    drive(2'b01, 6'd40, 1'b1, 1'b0);
    repeat (10) drive(2'b00, 6'd0, 1'b1, 1'b0);
    drive(2'b01, 6'd1, 1'b1, 1'b0);
    chk("trunc pulse", 64'(truncated), 64'd1);
    drive(2'b00, 6'd0, 1'b1, 1'b0);
    chk("trunc next addr", 64'(read_add), 64'h040);
    chk("trunc single", 64'(truncated), 64'd0);
    repeat (8) drive(2'b00, 6'd0, 1'b1, 1'b0);

    // Empty page still advances BX; done follows start by TMUX clocks.
    do_reset();
    drive(2'b01, 6'd0, 1'b1, 1'b0);
    for (int i = 1; i <= TMUX; i++) begin
      drive(2'b00, 6'd0, 1'b1, 1'b0);
      chk("empty no valid", 64'(valid_out), 64'd0);
      chk("done pulse", 64'(done[0]), 64'(i == TMUX - 1));
    end
    drive(2'b01, 6'd1, 1'b1, 1'b0);
    drive(2'b00, 6'd0, 1'b1, 1'b0);
    chk("empty next bx", 64'(read_add), 64'h040);
    repeat (8) drive(2'b00, 6'd0, 1'b1, 1'b0);

    // Pipelined reset mid-READ, coincident with a page start.
    do_reset();
    drive(2'b01, 6'd10, 1'b1, 1'b0);
    repeat (3) drive(2'b00, 6'd0, 1'b1, 1'b0);
    drive(2'b11, 6'd5, 1'b1, 1'b0);
    chk("s1 read_add", 64'(read_add), 64'h1C0);
    chk("s1 valid", 64'(valid_out), 64'd0);
    repeat (8) drive(2'b00, 6'd0, 1'b1, 1'b0);
    drive(2'b01, 6'd1, 1'b1, 1'b0);
    drive(2'b00, 6'd0, 1'b1, 1'b0);
    chk("s1 next bx0", 64'(read_add), 64'h000);
    repeat (8) drive(2'b00, 6'd0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      logic       r, s1, s0, e;
      logic [5:0] n;
      r  = ($urandom_range(0, 999) < 3);
      s1 = ($urandom_range(0, 999) < 4);
      s0 = ($urandom_range(0, 99) < 6);
      e  = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 3))
        0:       n = 6'd0;
        1:       n = 6'd63;
        2:       n = 6'($urandom_range(1, 8));
        default: n = 6'($urandom_range(0, 63));
      endcase
      drive({s1, s0}, n, e, r);
    end
    repeat (20) drive(2'b00, 6'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
